mat_stream_loader: RTL and testbench

- Upstream feeder for the complex matrix multiplier.
- Accepts one valid/ready stream of signed words in a fixed order: A real, A imag, B real, B imag, MAT_WORDS words each.
- Converts the stream into the multiplier's memory-write interface: one-hot we[3:0], Dir_M1/Dir_M2 and the four data buses.
- Replaces testbench/host-driven file loading with a synthesizable sequencer and reports completion to the control logic that starts the multiply.

---
 rtl/mat_stream_loader.sv | 148 ++++++++++++++
 tb/tb_mat_stream_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_loader.sv
// Stream-to-memory-write sequencer for the complex matrix multiplier: accepts
// A re, A im, B re, B im (MAT_WORDS words each) and turns each word into one write.
module mat_stream_loader #(
    parameter int WORD_LEN  = 16,
    parameter int ADDR_BITS = 7,
    parameter int MAT_WORDS = 64
) (
    input  logic                       src_clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_abort,
    input  logic signed [WORD_LEN-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 we,
    output logic [ADDR_BITS-1:0]       Dir_M1,
    output logic [ADDR_BITS-1:0]       Dir_M2,
    output logic signed [WORD_LEN-1:0] data_m1_real,
    output logic signed [WORD_LEN-1:0] data_m1_imag,
    output logic signed [WORD_LEN-1:0] data_m2_real,
    output logic signed [WORD_LEN-1:0] data_m2_imag,
    output logic                       busy,
    output logic                       load_done,
    output logic [1:0]                 phase
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(MAT_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_A_RE, S_A_IM, S_B_RE, S_B_IM, S_DONE
    } state_t;

    state_t                      state, state_nxt;
    logic [ADDR_BITS-1:0]        cnt, cnt_nxt;
    logic                        load_state, accept;

    logic [3:0]                  we_p0;
    logic [ADDR_BITS-1:0]        addr_m1_p0, addr_m2_p0;
    logic signed [WORD_LEN-1:0]  m1_re_p0, m1_im_p0, m2_re_p0, m2_im_p0;

    always_ff @(posedge src_clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        load_state = (state == S_A_RE) || (state == S_A_IM) ||
                     (state == S_B_RE) || (state == S_B_IM);
        // Abort must block the word on its own edge, so ready drops combinationally.
        in_ready   = load_state && !load_abort;
        accept     = in_ready && in_valid;
        busy       = load_state;
        load_done  = (state == S_DONE);
        state_nxt  = state;
        cnt_nxt    = cnt;

        case (state)
            S_A_IM:  phase = 2'd1;
            S_B_RE:  phase = 2'd2;
            S_B_IM:  phase = 2'd3;
            default: phase = 2'd0;
        endcase

        if (load_abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state_nxt = S_A_RE;
                        cnt_nxt   = '0;
                    end
                end
                S_DONE: state_nxt = S_IDLE;
                default: begin
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            cnt_nxt = '0;
                            case (state)
                                S_A_RE:  state_nxt = S_A_IM;
                                S_A_IM:  state_nxt = S_B_RE;
                                S_B_RE:  state_nxt = S_B_IM;
                                default: state_nxt = S_DONE;
                            endcase
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // p0: write stage, one cycle after the accept edge; unselected buses hold
    always_ff @(posedge src_clk or negedge rst) begin
        if (!rst) begin
            we_p0      <= '0;
            addr_m1_p0 <= '0;
            addr_m2_p0 <= '0;
            m1_re_p0   <= '0;
            m1_im_p0   <= '0;
            m2_re_p0   <= '0;
            m2_im_p0   <= '0;
        end else begin
            we_p0 <= 4'b0000;
            if (accept) begin
                case (state)
                    S_A_RE: begin
                        we_p0      <= 4'b0001;
                        addr_m1_p0 <= cnt;
                        m1_re_p0   <= in_data;
                    end
                    S_A_IM: begin
                        we_p0      <= 4'b0100;
                        addr_m1_p0 <= cnt;
                        m1_im_p0   <= in_data;
                    end
                    S_B_RE: begin
                        we_p0      <= 4'b0010;
                        addr_m2_p0 <= cnt;
                        m2_re_p0   <= in_data;
                    end
                    S_B_IM: begin
                        we_p0      <= 4'b1000;
                        addr_m2_p0 <= cnt;
                        m2_im_p0   <= in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign we           = we_p0;
    assign Dir_M1       = addr_m1_p0;
    assign Dir_M2       = addr_m2_p0;
    assign data_m1_real = m1_re_p0;
    assign data_m1_imag = m1_im_p0;
    assign data_m2_real = m2_re_p0;
    assign data_m2_imag = m2_im_p0;

endmodule

// File: tb/tb_mat_stream_loader.sv
// Bench for mat_stream_loader: word-index model checked every cycle plus
// hand-computed directed expectations.
module tb_mat_stream_loader;
    localparam int WL = 16;
    localparam int AB = 7;
    localparam int MW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [WL-1:0] in_data = '0;
    logic          in_ready, busy, load_done;
    logic [3:0]    we;
    logic [AB-1:0] Dir_M1, Dir_M2;
    logic [WL-1:0] d1r, d1i, d2r, d2i;
    logic [1:0]    phase;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0;

    mat_stream_loader #(.WORD_LEN(WL), .ADDR_BITS(AB), .MAT_WORDS(MW)) dut (
        .src_clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .we(we),
        .Dir_M1(Dir_M1), .Dir_M2(Dir_M2),
        .data_m1_real(d1r), .data_m1_imag(d1i), .data_m2_real(d2r), .data_m2_imag(d2i),
        .busy(busy), .load_done(load_done), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a load is a run of 4*MW words indexed k; part = k/MW, address = k%MW.
    bit            m_active = 1'b0;
    int            m_k = 0;
    bit            m_done = 1'b0;
    logic [3:0]    m_we = '0;
    logic [AB-1:0] m_a1 = '0, m_a2 = '0;
    logic [WL-1:0] m_d [4] = '{default: '0};

    always @(posedge clk or negedge rst) begin : model
        int p, w;
        if (!rst) begin
            m_active <= 1'b0; m_k <= 0; m_done <= 1'b0; m_we <= '0;
            m_a1 <= '0; m_a2 <= '0;
            m_d[0] <= '0; m_d[1] <= '0; m_d[2] <= '0; m_d[3] <= '0;
        end else begin
            m_we   <= 4'b0000;
            m_done <= 1'b0;
            if (load_abort) begin
                m_active <= 1'b0;
                m_k      <= 0;
            end else if (m_active && in_valid) begin
                p = m_k / MW;
                w = m_k % MW;
                m_d[p] <= in_data;
                if (p < 2) m_a1 <= AB'(w); else m_a2 <= AB'(w);
                m_we <= (p == 0) ? 4'b0001 : (p == 1) ? 4'b0100 : (p == 2) ? 4'b0010 : 4'b1000;
                if (m_k + 1 == 4 * MW) begin
                    m_active <= 1'b0;
                    m_k      <= 0;
                    m_done   <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (!m_active && !m_done && load_start) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (rst) begin
            chk("we", 32'(we), 32'(m_we));
            chk("Dir_M1", 32'(Dir_M1), 32'(m_a1));
            chk("Dir_M2", 32'(Dir_M2), 32'(m_a2));
            chk("data_m1_real", 32'(d1r), 32'(m_d[0]));
            chk("data_m1_imag", 32'(d1i), 32'(m_d[1]));
            chk("data_m2_real", 32'(d2r), 32'(m_d[2]));
            chk("data_m2_imag", 32'(d2i), 32'(m_d[3]));
            chk("in_ready", 32'(in_ready), 32'(m_active && !load_abort));
            chk("busy", 32'(busy), 32'(m_active));
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("phase", 32'(phase), m_active ? 32'(m_k / MW) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [WL-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic abort_now();
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_Dir_M1"}, 32'(Dir_M1), 32'd0);
        chk({tag, "_Dir_M2"}, 32'(Dir_M2), 32'd0);
        chk({tag, "_data"}, 32'(d1r | d1i | d2r | d2i), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Full load, word value = index
        start();
        for (int i = 0; i < 4 * MW; i++) begin
            send(WL'(i));
            if (i == 0) begin
                chk("full_we0", 32'(we), 32'h1);
                chk("full_a0", 32'(Dir_M1), 32'd0);
                chk("full_d0", 32'(d1r), 32'h0);
            end
            if (i == 64) begin
                chk("full_we64", 32'(we), 32'h4);
                chk("full_a64", 32'(Dir_M1), 32'd0);
                chk("full_d64", 32'(d1i), 32'h40);
                chk("full_ph64", 32'(phase), 32'd1);
            end
            if (i == 128) begin
                chk("full_we128", 32'(we), 32'h2);
                chk("full_a128", 32'(Dir_M2), 32'd0);
                chk("full_d128", 32'(d2r), 32'h80);
            end
            if (i == 255) begin
                chk("full_we255", 32'(we), 32'h8);
                chk("full_a255", 32'(Dir_M2), 32'd63);
                chk("full_d255", 32'(d2i), 32'hFF);
                chk("full_done", 32'(load_done), 32'd1);
                chk("full_busy", 32'(busy), 32'd0);
            end
        end
        tick();
        chk("full_done_low", 32'(load_done), 32'd0);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);

        // Stalls during A real
        start();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = WL'(16'h0100 + i);
            tick();
            if (i % 2 == 0) begin
                chk("stall_we", 32'(we), 32'h1);
                chk("stall_addr", 32'(Dir_M1), 32'(i / 2));
            end else begin
                chk("stall_gap_we", 32'(we), 32'h0);
            end
        end
        in_valid = 1'b0;
        abort_now();

        // Part boundary A real -> A imag
        start();
        for (int i = 0; i < 63; i++) send(WL'(i));
        chk("bnd_phase0", 32'(phase), 32'd0);
        send(16'h1234);
        chk("bnd_we63", 32'(we), 32'h1);
        chk("bnd_a63", 32'(Dir_M1), 32'd63);
        chk("bnd_d63", 32'(d1r), 32'h1234);
        chk("bnd_phase1", 32'(phase), 32'd1);
        send(16'h5678);
        chk("bnd_we64", 32'(we), 32'h4);
        chk("bnd_a64", 32'(Dir_M1), 32'd0);
        chk("bnd_d64", 32'(d1i), 32'h5678);
        abort_now();

        // Abort after 10 B-real words
        start();
        for (int i = 0; i < 138; i++) send(WL'(16'h2000 + i));
        load_abort = 1'b1;
        in_valid   = 1'b1;
        in_data    = 16'hDEAD;
        #1 chk("abort_ready", 32'(in_ready), 32'd0);
        tick();
        load_abort = 1'b0;
        in_valid   = 1'b0;
        chk("abort_we", 32'(we), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(load_done), 32'd0);
        d0 = done_cnt;
        start();
        send(16'hAAAA);
        chk("restart_we", 32'(we), 32'h1);
        chk("restart_a", 32'(Dir_M1), 32'd0);
        chk("restart_d", 32'(d1r), 32'hAAAA);
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        abort_now();

        // Async reset during A imag word 20
        start();
        for (int i = 0; i < 84; i++) send(WL'(i + 1));
        in_valid = 1'b1;
        in_data  = 16'h7777;
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_idle_ready", 32'(in_ready), 32'd0);
        chk("rst_idle_we", 32'(we), 32'h0);
        in_valid = 1'b0;
        start();
        send(16'h0BEE);
        chk("rst_restart_we", 32'(we), 32'h1);
        chk("rst_restart_a", 32'(Dir_M1), 32'd0);
        abort_now();

        // load_start ignored while busy and in DONE; 0x8000 passes unchanged
        d0 = done_cnt;
        start();
        for (int i = 0; i < 4 * MW; i++) begin
            if (i == 133) load_start = 1'b1;
            send((i == 135) ? 16'h8000 : WL'(i));
            load_start = 1'b0;
            if (i == 133) chk("ign_phase", 32'(phase), 32'd2);
            if (i == 135) begin
                chk("ign_d8000", 32'(d2r), 32'h8000);
                chk("ign_a7", 32'(Dir_M2), 32'd7);
            end
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ign_done_busy", 32'(busy), 32'd0);
        chk("ign_done_ready", 32'(in_ready), 32'd0);
        chk("ign_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
